// File: rtl/cf_pkg.sv
// Shared definitions for the CF coder control blocks: sort sequencer state codes and
// default datapath sizing.
package cf_pkg;

    typedef enum logic [1:0] {
        SS_IDLE = 2'd0,
        SS_EVEN = 2'd1,
        SS_ODD  = 2'd2,
        SS_DONE = 2'd3
    } sort_state_e;

    localparam int unsigned N_SYM_DEF = 6;
    localparam int unsigned CW_DEF    = 8;
    localparam int unsigned IW_DEF    = 3;

endpackage

// File: rtl/sort_sched.sv
// Odd-even transposition sort sequencer: one compare-swap pair per cycle on a shared
// comparator, descending by count, with early exit after a round that makes no swap.
module sort_sched
    import cf_pkg::*;
#(
    parameter int unsigned N_SYM = N_SYM_DEF,
    parameter int unsigned CW    = CW_DEF,
    parameter int unsigned IW    = IW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] cnt_a,
    input  logic [CW-1:0] cnt_b,
    output logic [IW-1:0] idx_a,
    output logic [IW-1:0] idx_b,
    output logic          swap_en,
    output logic          busy,
    output logic          done
);

    localparam logic [IW-1:0] LAST_EVEN = IW'(N_SYM / 2 - 1);
    localparam logic [IW-1:0] LAST_ODD  = IW'(N_SYM / 2 - 2);
    localparam logic [IW-1:0] MAX_ROUND = IW'(N_SYM / 2);

    sort_state_e   state_q;
    logic [IW-1:0] pair_q;
    logic [IW-1:0] round_q;
    logic          swapped_q;

    logic [IW-1:0] round_next;
    logic          swap_any;

    always_comb begin
        busy    = (state_q == SS_EVEN) || (state_q == SS_ODD);
        done    = (state_q == SS_DONE);
        idx_a   = '0;
        if (state_q == SS_EVEN) begin
            idx_a = {pair_q[IW-2:0], 1'b0};
        end else if (state_q == SS_ODD) begin
            idx_a = {pair_q[IW-2:0], 1'b1};
        end
        idx_b   = idx_a + IW'(1);
        // Strict compare: equal counts stay put, keeping the sort stable.
        swap_en = busy && (cnt_a < cnt_b);
    end

    assign round_next = round_q + IW'(1);
    // Includes this cycle's swap so the last pair of a round can veto the early exit.
    assign swap_any   = swapped_q | swap_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SS_IDLE;
            pair_q    <= '0;
            round_q   <= '0;
            swapped_q <= 1'b0;
        end else begin
            unique case (state_q)
                SS_IDLE, SS_DONE: begin
                    if (start) begin
                        state_q   <= SS_EVEN;
                        pair_q    <= '0;
                        round_q   <= '0;
                        swapped_q <= 1'b0;
                    end else begin
                        state_q <= SS_IDLE;
                    end
                end
                SS_EVEN: begin
                    swapped_q <= swap_any;
                    if (pair_q == LAST_EVEN) begin
                        state_q <= SS_ODD;
                        pair_q  <= '0;
                    end else begin
                        pair_q <= pair_q + IW'(1);
                    end
                end
                SS_ODD: begin
                    swapped_q <= swap_any;
                    if (pair_q == LAST_ODD) begin
                        round_q <= round_next;
                        pair_q  <= '0;
                        if (!swap_any || (round_next == MAX_ROUND)) begin
                            state_q <= SS_DONE;
                        end else begin
                            state_q   <= SS_EVEN;
                            swapped_q <= 1'b0;
                        end
                    end else begin
                        pair_q <= pair_q + IW'(1);
                    end
                end
                default: state_q <= SS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_sched.sv
// Bench for sort_sched: models the count/symbol register file, applies swap_en, and checks
// sequencing, latency and sorted results against a table of vectors and a scoreboard.
module tb_sort_sched;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [2:0] idx_a;
    logic [2:0] idx_b;
    logic       swap_en;
    logic       busy;
    logic       done;

    logic [7:0] cnt_mem [0:7];
    int         sym_mem [0:7];

    assign cnt_a = cnt_mem[idx_a];
    assign cnt_b = cnt_mem[idx_b];

    always #5 clk = ~clk;

    sort_sched #(
        .N_SYM(6),
        .CW   (8),
        .IW   (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .cnt_a  (cnt_a),
        .cnt_b  (cnt_b),
        .idx_a  (idx_a),
        .idx_b  (idx_b),
        .swap_en(swap_en),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        int cnt[6];
        int exp_c[6];
        int exp_s[6];
        int lat;
    } vec_t;

    typedef struct {
        int c[6];
        int s[6];
        int lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Called at a negedge; crosses one posedge, applies the datapath swap just after it,
    // and returns at the next negedge.
    task automatic tick();
        logic pend;
        int   ia;
        int   tc;
        pend = swap_en;
        ia   = int'(idx_a);
        @(posedge clk);
        #1;
        if (pend) begin
            tc              = sym_mem[ia];
            sym_mem[ia]     = sym_mem[ia + 1];
            sym_mem[ia + 1] = tc;
            {cnt_mem[ia], cnt_mem[ia + 1]} = {cnt_mem[ia + 1], cnt_mem[ia]};
        end
        @(negedge clk);
    endtask

    task automatic load(input int c[6]);
        for (int i = 0; i < 8; i++) begin
            cnt_mem[i] = (i < 6) ? 8'(c[i]) : 8'd0;
            sym_mem[i] = i;
        end
    endtask

    task automatic run_sort(input vec_t v);
        exp_t e;
        exp_t got_e;
        int   got;
        int   ph;
        int   ea;
        load(v.cnt);
        e.c   = v.exp_c;
        e.s   = v.exp_s;
        e.lat = v.lat;
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        got   = -1;
        for (int n = 1; n <= 40; n++) begin
            if (done) begin
                got = n;
                chk("busy_low_at_done", int'(busy), 0);
                break;
            end
            ph = (n - 1) % 5;
            ea = (ph < 3) ? 2 * ph : 2 * (ph - 3) + 1;
            chk("busy", int'(busy), 1);
            chk("idx_a", int'(idx_a), ea);
            chk("idx_b", int'(idx_b), ea + 1);
            chk("swap_en", int'(swap_en), int'(cnt_mem[ea] < cnt_mem[ea + 1]));
            tick();
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            got_e = sb.pop_front();
            chk("done_latency", got, got_e.lat);
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("count[%0d]", i), int'(cnt_mem[i]), got_e.c[i]);
                chk($sformatf("symbol[%0d]", i), sym_mem[i], got_e.s[i]);
            end
        end
        tick();
        chk("done_one_cycle", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        int   sorted6[6];
        int   rev6[6];
        int   saw;
        vecs[0] = '{'{9, 7, 5, 3, 2, 1}, '{9, 7, 5, 3, 2, 1}, '{0, 1, 2, 3, 4, 5}, 6};
        vecs[1] = '{'{0, 1, 2, 3, 4, 5}, '{5, 4, 3, 2, 1, 0}, '{5, 4, 3, 2, 1, 0}, 16};
        vecs[2] = '{'{4, 4, 8, 4, 1, 8}, '{8, 8, 4, 4, 4, 1}, '{2, 5, 0, 1, 3, 4}, 16};
        vecs[3] = '{'{5, 6, 4, 3, 2, 1}, '{6, 5, 4, 3, 2, 1}, '{1, 0, 2, 3, 4, 5}, 11};
        vecs[4] = '{'{3, 3, 3, 3, 3, 3}, '{3, 3, 3, 3, 3, 3}, '{0, 1, 2, 3, 4, 5}, 6};
        vecs[5] = '{'{255, 0, 255, 0, 128, 128}, '{255, 255, 128, 128, 0, 0},
                    '{0, 2, 4, 5, 1, 3}, 16};
        sorted6 = '{9, 7, 5, 3, 2, 1};
        rev6    = '{0, 1, 2, 3, 4, 5};
        load(sorted6);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_idx_a", int'(idx_a), 0);
        chk("rst_idx_b", int'(idx_b), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_swap_en", int'(swap_en), 0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) run_sort(vecs[v]);

        // start held for 20 cycles: back-to-back sorts via DONE -> EVEN
        load(sorted6);
        start = 1'b1;
        tick();
        for (int n = 1; n <= 20; n++) begin
            chk($sformatf("held_done@%0d", n), int'(done), int'(n % 6 == 0));
            chk($sformatf("held_busy@%0d", n), int'(busy), int'(n % 6 != 0));
            tick();
        end
        start = 1'b0;
        saw   = 0;
        for (int n = 0; n < 20 && (busy || done); n++) tick();
        chk("held_settles_idle", int'(busy || done), 0);

        // Asynchronous reset in the middle of a sort
        load(rev6);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 1; n < 7; n++) tick();
        chk("pre_reset_busy", int'(busy), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_swap_en", int'(swap_en), 0);
        chk("async_idx_a", int'(idx_a), 0);
        tick();
        reset = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (done || busy) saw = 1;
            tick();
        end
        chk("no_done_after_reset", saw, 0);

        run_sort(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
